timer_controller: RTL



---
 rtl/timer_defs.sv | 19 +
 rtl/timer_controller_count_step.sv | 30 +++
 rtl/timer_controller.sv | 136 +++++++++++++
 3 files changed

// File: rtl/timer_defs.sv
`default_nettype none
// ============================================================================
// timer_defs : shared state encoding and default sizing for the kitchen timer
// Revision   : 1.0
// ============================================================================
package timer_defs;

  localparam int              WIDTH_DEF     = 12;
  localparam logic [11:0]     MAX_COUNT_DEF = 12'd3599;

  typedef enum logic [1:0] {
    ST_SET   = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_ALARM = 2'd3
  } state_e;

endpackage
`default_nettype wire

// File: rtl/timer_controller_count_step.sv
`default_nettype none
// ============================================================================
// count_step : one-second up/down step with wrap at 0 and MAX_COUNT
// Revision   : 1.0
// ============================================================================
module count_step
  import timer_defs::*;
#(
  parameter int               WIDTH     = WIDTH_DEF,
  parameter logic [WIDTH-1:0] MAX_COUNT = WIDTH'(MAX_COUNT_DEF)
) (
  input  logic [WIDTH-1:0] value_i,
  input  logic             up_i,
  input  logic             down_i,
  output logic [WIDTH-1:0] next_o
);

  // Up wins over down; out-of-range inputs are pulled back into 0..MAX_COUNT.
  always_comb begin
    next_o = value_i;
    if (up_i) begin
      next_o = (value_i >= MAX_COUNT) ? '0 : value_i + WIDTH'(1);
    end else if (down_i) begin
      next_o = ((value_i == '0) || (value_i > MAX_COUNT)) ? MAX_COUNT
                                                          : value_i - WIDTH'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/timer_controller.sv
`default_nettype none
// ============================================================================
// timer_controller : SET/RUN/PAUSE/ALARM sequencer owning the time register
// Revision         : 1.0
// ============================================================================
module timer_controller
  import timer_defs::*;
#(
  parameter int               WIDTH       = WIDTH_DEF,
  parameter logic [WIDTH-1:0] MAX_COUNT   = WIDTH'(MAX_COUNT_DEF),
  parameter int               ALARM_TICKS = 10
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             tick_1hz,
  input  logic             btn_up,
  input  logic             btn_down,
  input  logic             btn_start,
  input  logic             btn_clear,
  output logic [WIDTH-1:0] time_value,
  output logic             running,
  output logic             alarm,
  output logic [1:0]       state
);

  localparam int CW = $clog2(ALARM_TICKS + 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] value_q, value_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             armed_q;
  logic             step_up, step_down;
  logic [WIDTH-1:0] step_next;
  logic             any_btn;

  count_step #(
    .WIDTH     (WIDTH),
    .MAX_COUNT (MAX_COUNT)
  ) u_count_step (
    .value_i (value_q),
    .up_i    (step_up),
    .down_i  (step_down),
    .next_o  (step_next)
  );

  assign any_btn = btn_up | btn_down | btn_start | btn_clear;

  // armed_q masks every pulse on the first edge after reset release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_SET;
      value_q <= '0;
      cnt_q   <= '0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      value_q <= value_d;
      cnt_q   <= cnt_d;
      armed_q <= 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    value_d   = value_q;
    cnt_d     = cnt_q;
    step_up   = 1'b0;
    step_down = 1'b0;
    if (armed_q) begin
      case (state_q)
        ST_SET: begin
          step_up   = btn_up;
          step_down = btn_down;
          if (btn_clear) begin
            value_d = '0;
          end else if (btn_start) begin
            if (value_q != '0) state_d = ST_RUN;
          end else begin
            value_d = step_next;
          end
        end
        ST_RUN: begin
          step_down = tick_1hz;
          if (btn_clear) begin
            state_d = ST_SET;
            value_d = '0;
          end else if (btn_start) begin
            state_d = ST_PAUSE;
          end else if (tick_1hz) begin
            value_d = step_next;
            // Reaching zero enters ALARM on the same edge; the step never wraps here.
            if (value_q <= WIDTH'(1)) begin
              state_d = ST_ALARM;
              value_d = '0;
              cnt_d   = '0;
            end
          end
        end
        ST_PAUSE: begin
          if (btn_clear) begin
            state_d = ST_SET;
            value_d = '0;
          end else if (btn_start) begin
            state_d = ST_RUN;
          end
        end
        ST_ALARM: begin
          value_d = '0;
          if (any_btn) begin
            state_d = ST_SET;
            cnt_d   = '0;
          end else if (tick_1hz) begin
            if (cnt_q == CW'(ALARM_TICKS - 1)) begin
              state_d = ST_SET;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
        default: begin
          state_d = ST_SET;
          value_d = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign time_value = value_q;
  assign running    = (state_q == ST_RUN);
  assign alarm      = (state_q == ST_ALARM);
  assign state      = state_q;

endmodule
`default_nettype wire
